// File: rtl/lcd_read_ctrl.sv
// Read-side controller for an HD44780-compatible character LCD.
// Issues timed RW=1 accesses for status (BF/AC) or data bytes, with optional busy-flag polling.
module lcd_read_ctrl #(
    parameter int SIZE_DATA = 8,
    parameter int CNT_AS    = 2,
    parameter int CNT_EH    = 25,
    parameter int CNT_EL    = 25,
    parameter int MAX_POLL  = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic                 i_rs,
    input  logic                 i_poll,
    input  logic [SIZE_DATA-1:0] i_LCD_DATA,
    output logic                 o_LCD_E,
    output logic                 o_LCD_RW,
    output logic                 o_LCD_RS,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_busy_flag,
    output logic [6:0]           o_addr,
    output logic                 o_timeout
);

    // state | meaning
    // IDLE  | RW=0, E=0, waiting for i_req
    // SETUP | RW=1, RS valid, E=0 for CNT_AS cycles
    // EHIGH | E=1 for CNT_EH cycles, bus sampled on the last one
    // EHOLD | E=0, RW/RS held for CNT_EL cycles, decide re-poll
    // DONE  | one-cycle o_valid, RW=0

    localparam int MAX_AB  = (CNT_AS > CNT_EH) ? CNT_AS : CNT_EH;
    localparam int MAX_ABC = (MAX_AB > CNT_EL) ? MAX_AB : CNT_EL;
    localparam int CNT_MAX = (MAX_ABC > MAX_POLL) ? MAX_ABC : MAX_POLL;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EHIGH,
        EHOLD,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   poll_cnt;
    logic            rs_q;
    logic            poll_q;

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            poll_cnt    <= '0;
            rs_q        <= 1'b0;
            poll_q      <= 1'b0;
            o_LCD_E     <= 1'b0;
            o_LCD_RW    <= 1'b0;
            o_LCD_RS    <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_busy_flag <= 1'b0;
            o_addr      <= '0;
            o_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_LCD_E  <= 1'b0;
                    o_LCD_RW <= 1'b0;
                    o_valid  <= 1'b0;
                    if (i_req) begin
                        rs_q      <= i_rs;
                        poll_q    <= i_poll & ~i_rs;
                        o_timeout <= 1'b0;
                        poll_cnt  <= '0;
                        cnt       <= CW'(CNT_AS - 1);
                        o_LCD_RW  <= 1'b1;
                        o_LCD_RS  <= i_rs;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        o_LCD_E <= 1'b1;
                        cnt     <= CW'(CNT_EH - 1);
                        state   <= EHIGH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EHIGH: begin
                    if (cnt == '0) begin
                        o_LCD_E <= 1'b0;
                        o_data  <= i_LCD_DATA;
                        if (!rs_q) begin
                            o_busy_flag <= i_LCD_DATA[7];
                            o_addr      <= i_LCD_DATA[6:0];
                        end
                        cnt   <= CW'(CNT_EL - 1);
                        state <= EHOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EHOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (poll_q && o_busy_flag && (poll_cnt < CW'(MAX_POLL - 1))) begin
                        // Still busy: go straight into another status read, RW stays high
                        poll_cnt <= poll_cnt + CW'(1);
                        cnt      <= CW'(CNT_AS - 1);
                        state    <= SETUP;
                    end else begin
                        o_timeout <= poll_q & o_busy_flag;
                        o_LCD_RW  <= 1'b0;
                        o_LCD_RS  <= 1'b0;
                        o_valid   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    o_LCD_E  <= 1'b0;
                    o_LCD_RW <= 1'b0;
                    o_valid  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Self-checking bench for lcd_read_ctrl: directed vector table, hand sequences and random
// transactions checked cycle by cycle against a transaction-level timing model.
`timescale 1ns/1ps
module tb_lcd_read_ctrl;

    localparam int AS  = 2;
    localparam int EH  = 25;
    localparam int EL  = 25;
    localparam int MP  = 4;
    localparam int PER = AS + EH + EL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       rs;
    logic       poll;
    logic [7:0] bus;
    logic       lcd_e, lcd_rw, lcd_rs, ready, valid, busy_flag, timeout;
    logic [7:0] data;
    logic [6:0] addr;

    int n_pass  = 0;
    int n_total = 0;

    logic       m_bf   = 1'b0;
    logic [6:0] m_addr = '0;

    always #10 clk = ~clk;

    lcd_read_ctrl #(
        .SIZE_DATA(8), .CNT_AS(AS), .CNT_EH(EH), .CNT_EL(EL), .MAX_POLL(MP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_rs(rs), .i_poll(poll),
        .i_LCD_DATA(bus), .o_LCD_E(lcd_e), .o_LCD_RW(lcd_rw), .o_LCD_RS(lcd_rs),
        .o_ready(ready), .o_valid(valid), .o_data(data), .o_busy_flag(busy_flag),
        .o_addr(addr), .o_timeout(timeout)
    );

    typedef struct {
        logic            rs;
        logic            poll;
        logic [3:0][7:0] bus;
        int              pulse;
        int              reads;
        logic [7:0]      data;
        logic            bf;
        logic [6:0]      addr;
        logic            to;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Accept happens on the edge right after this task starts (cycle 0); cycle c is sampled
    // on the falling edge after rising edge c-1.
    task automatic exec_txn(input vec_t v, input string tag);
        int last;
        int ph;
        last = v.reads * PER;
        rs   = v.rs;
        poll = v.poll;
        bus  = v.bus[0];
        req  = 1'b1;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (v.pulse != 0 && c == v.pulse) req = 1'b1;
            if (v.pulse != 0 && c == v.pulse + 1) req = 1'b0;
            if (c <= last) begin
                ph = (c - 1) % PER;
                chk({tag, " E"},       32'(lcd_e), 32'(ph >= AS && ph < AS + EH));
                chk({tag, " RW"},      32'(lcd_rw), 32'd1);
                chk({tag, " RS"},      32'(lcd_rs), 32'(v.rs));
                chk({tag, " ready"},   32'(ready), 32'd0);
                chk({tag, " valid"},   32'(valid), 32'd0);
                chk({tag, " timeout"}, 32'(timeout), 32'd0);
                if (c > 1 && ph == 0) bus = v.bus[(c - 1) / PER];
            end else if (c == last + 1) begin
                chk({tag, " valid@end"}, 32'(valid), 32'd1);
                chk({tag, " RW@end"},    32'(lcd_rw), 32'd0);
                chk({tag, " E@end"},     32'(lcd_e), 32'd0);
                chk({tag, " ready@end"}, 32'(ready), 32'd0);
                chk({tag, " data"},      32'(data), 32'(v.data));
                chk({tag, " busy_flag"}, 32'(busy_flag), 32'(v.bf));
                chk({tag, " addr"},      32'(addr), 32'(v.addr));
                chk({tag, " timeout@end"}, 32'(timeout), 32'(v.to));
            end else begin
                chk({tag, " ready@idle"}, 32'(ready), 32'd1);
                chk({tag, " valid@idle"}, 32'(valid), 32'd0);
                chk({tag, " RW@idle"},    32'(lcd_rw), 32'd0);
            end
        end
        m_bf   = v.bf;
        m_addr = v.addr;
    endtask

    // Transaction-level reference: how many reads happen and what the result registers hold.
    task automatic model(inout vec_t v);
        v.reads = 1;
        if (!v.rs && v.poll)
            while (v.bus[v.reads - 1][7] && v.reads < MP) v.reads++;
        v.data = v.bus[v.reads - 1];
        v.to   = !v.rs && v.poll && v.data[7];
        v.bf   = v.rs ? m_bf : v.data[7];
        v.addr = v.rs ? m_addr : v.data[6:0];
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t rv;
        int   vq[$];
        int   nvalid;

        tbl[0] = '{rs:0, poll:0, bus:{4{8'h45}}, pulse:0, reads:1, data:8'h45, bf:0, addr:7'h45, to:0};
        tbl[1] = '{rs:1, poll:0, bus:{4{8'hA7}}, pulse:0, reads:1, data:8'hA7, bf:0, addr:7'h45, to:0};
        tbl[2] = '{rs:0, poll:1, bus:{8'h12, 8'h80, 8'h80, 8'h80}, pulse:0, reads:4, data:8'h12, bf:0, addr:7'h12, to:0};
        tbl[3] = '{rs:0, poll:1, bus:{4{8'hFF}}, pulse:0, reads:4, data:8'hFF, bf:1, addr:7'h7F, to:1};
        tbl[4] = '{rs:1, poll:1, bus:{4{8'h80}}, pulse:0, reads:1, data:8'h80, bf:1, addr:7'h7F, to:0};
        tbl[5] = '{rs:0, poll:0, bus:{4{8'h33}}, pulse:35, reads:1, data:8'h33, bf:0, addr:7'h33, to:0};
        tbl[6] = '{rs:0, poll:1, bus:{8'h80, 8'h80, 8'h80, 8'h21}, pulse:0, reads:1, data:8'h21, bf:0, addr:7'h21, to:0};

        rst_n = 1'b0; req = 1'b0; rs = 1'b0; poll = 1'b0; bus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset E", 32'(lcd_e), 32'd0);
        chk("reset RW", 32'(lcd_rw), 32'd0);
        chk("reset RS", 32'(lcd_rs), 32'd0);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset data", 32'(data), 32'd0);
        chk("reset timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) exec_txn(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back: i_req held high
        rs = 1'b0; poll = 1'b0; bus = 8'h05; req = 1'b1;
        for (int c = 1; c <= 220; c++) begin
            @(negedge clk);
            if (valid) vq.push_back(c);
            if (c == 53 || c == 54) chk($sformatf("b2b RW gap c%0d", c), 32'(lcd_rw), 32'd0);
            if (c == 55) chk("b2b RW reaccept", 32'(lcd_rw), 32'd1);
            if (c == 163) req = 1'b0;
        end
        chk("b2b valid count", 32'(vq.size()), 32'd4);
        for (int i = 0; i < 4 && i < vq.size(); i++)
            chk($sformatf("b2b valid%0d cycle", i), 32'(vq[i]), 32'(53 + 54 * i));
        m_bf = 1'b0; m_addr = 7'h05;

        // Reset during EHIGH
        rs = 1'b0; poll = 1'b0; bus = 8'h45; req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
        end
        chk("rst-mid E before", 32'(lcd_e), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst-mid E", 32'(lcd_e), 32'd0);
        chk("rst-mid RW", 32'(lcd_rw), 32'd0);
        chk("rst-mid ready", 32'(ready), 32'd1);
        chk("rst-mid data", 32'(data), 32'd0);
        chk("rst-mid addr", 32'(addr), 32'd0);
        chk("rst-mid busy_flag", 32'(busy_flag), 32'd0);
        nvalid = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (valid || lcd_rw) nvalid++;
        end
        chk("rst-mid no activity", 32'(nvalid), 32'd0);
        m_bf = 1'b0; m_addr = '0;

        for (int i = 0; i < 16; i++) begin
            rv.rs    = 1'($urandom_range(0, 3) == 0);
            rv.poll  = 1'($urandom_range(0, 1));
            rv.pulse = 0;
            for (int k = 0; k < 4; k++) begin
                rv.bus[k] = 8'($urandom);
                rv.bus[k][7] = ($urandom_range(0, 3) != 0);
            end
            model(rv);
            exec_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
